n64_joybus_sniffer: RTL
=======================

N64_JOYBUS_SNIFFER -- requirements
Module: n64_joybus_sniffer

Interface
REQ-001 SHALL have parameter CMD_BYTE, default 8'h01, the joybus command byte (MSB transmitted first) that arms response capture.
REQ-002 SHALL have parameter RESP_BITS, default 32, the number of response data bits captured (range 8..64).
REQ-003 SHALL have parameter WAIT_W, default 6, the width of the wait/idle counter.
REQ-004 SHALL have parameter IGR_FRAMES, default 2, the number of consecutive matching frames required for an IGR hit (range 1..15).
REQ-005 SHALL have port CLK_4M, input, 1 bit: the single clock, 4 MHz.
REQ-006 SHALL have port nSRST_4M, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port CTRL, input, 1 bit: the raw, asynchronous joybus line.
REQ-008 SHALL have port ctrl_data_o, output, RESP_BITS bits: the last complete response, bit 0 = first received bit.
REQ-009 SHALL have port ctrl_valid_o, output, 1 bit: new data is available, held until acknowledged.
REQ-010 SHALL have port ctrl_ack_i, input, 1 bit: consumer acknowledge, one cycle.
REQ-011 SHALL have port overrun_o, output, 1 bit: sticky flag indicating that a frame overwrote unacknowledged data.
REQ-012 SHALL have port err_o, output, 1 bit: one-cycle pulse on a frame abort.
REQ-013 SHALL have ports igr_mask_i and igr_pattern_i, input, RESP_BITS bits each: the in-game-reset combo compare.
REQ-014 SHALL have port igr_en_i, input, 1 bit: enables IGR detection.
REQ-015 SHALL have port igr_hit_o, output, 1 bit: one-cycle pulse on an IGR hit.

Function
REQ-016 SHALL sample CTRL through a 2-FF synchroniser plus a 1-cycle history register.
- negedge = hist high and sync low.
- posedge = hist low and sync high.
REQ-017 SHALL clear the wait counter on any edge; otherwise the counter increments and saturates at all-ones.
REQ-018 SHALL latch the wait count into low_cnt on a posedge. On the next negedge the decoded bit = (low_cnt < wait count), i.e. high phase longer than low phase gives 1.
REQ-019 SHALL implement states IDLE, CMD, RESP:
- IDLE -> CMD: on a negedge while the wait counter is saturated; clear the bit counter.
- CMD: shift in 8 bits. On the 9th negedge (stop/response start), go to RESP if the byte equals CMD_BYTE, else go to IDLE.
- RESP: shift in RESP_BITS bits. On the negedge that decodes bit RESP_BITS-1, load ctrl_data_o and go to IDLE.
REQ-020 SHALL treat wait-counter saturation while in CMD or RESP as a timeout:
- go to IDLE;
- pulse err_o for one cycle;
- leave ctrl_data_o unchanged.
REQ-021 SHALL NOT treat a command mismatch as an error (no err_o pulse).
REQ-022 SHALL assert ctrl_valid_o on the cycle after ctrl_data_o is loaded and hold it until ctrl_ack_i is sampled high.
REQ-023 SHALL give load priority when a load and ctrl_ack_i occur in the same cycle: ctrl_valid_o stays high, and overrun_o is not set.
REQ-024 SHALL set overrun_o when a load occurs while ctrl_valid_o is high and no ack occurs in that cycle. Only reset clears overrun_o.
REQ-025 SHALL update the IGR match counter on each load when igr_en_i is high:
- if ((data XOR pattern) AND mask) == 0, increment (saturating);
- otherwise clear it.
REQ-026 SHALL pulse igr_hit_o once, on the load where the counter reaches IGR_FRAMES. No further pulse until a non-matching frame clears the counter.
REQ-027 SHALL clear the IGR match counter immediately when igr_en_i is low.
REQ-028 SHALL size the bit counter to clog2(RESP_BITS)+1 and compare it exactly, with no wrap.

Reset
REQ-029 SHALL, while nSRST_4M is low, put all state in its reset value:
- state = IDLE;
- synchroniser/history = all-ones (line idle high);
- counters = 0;
- ctrl_data_o = 0;
- ctrl_valid_o, overrun_o, err_o and igr_hit_o = 0.
REQ-030 SHALL discard any partial frame on reset mid-frame, produce no err_o pulse, and require a saturated idle before the next frame is accepted.

Structure
REQ-031 SHALL place the state encodings and the bit-timing constants for the benches in the shared n64adv parameter header.
REQ-032 SHALL factor the edge detector plus the bit decoder (REQ-016..018) into one sub-module, joybus_bit_decoder.

Verification
REQ-033 SHALL cover: 20 us idle high, then command 8'h01 (bit0 = 12 low/4 high cycles, bit1 = 4 low/12 high), stop bit, response 32'h0000_8000 -> ctrl_data_o = 32'h0000_8000, ctrl_valid_o asserted, err_o never pulsed.
REQ-034 SHALL cover: command 8'h00 followed by a response -> ctrl_data_o unchanged, ctrl_valid_o stays 0, no err_o.
REQ-035 SHALL cover: line held high for 20 us after response bit 10 -> err_o pulses once, state returns to IDLE, and the next valid frame is captured correctly.
REQ-036 SHALL cover: two frames with no ack, then ack coincident with a third load -> overrun_o = 1 and ctrl_valid_o stays 1.
REQ-037 SHALL cover: IGR_FRAMES = 2, mask 32'h0000_FFFF, pattern 32'h0000_3020, frames match, match, match, mismatch, match, match -> igr_hit_o pulses on frames 2 and 6 only.
REQ-038 SHALL cover: nSRST_4M asserted mid-response -> all outputs go to 0 asynchronously, and the frame is not completed.

Source files
------------

// File: rtl/n64_joybus_sniffer_pkg.sv
// Shared n64adv parameter header for the joybus sniffer: sniffer state encoding,
// fixed frame sizes and the nominal joybus bit timing at 4 MHz.
package n64_joybus_sniffer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int unsigned CMD_BITS  = 8;
  localparam int unsigned IGR_CNT_W = 4;

  // Nominal line timing in CLK_4M cycles: one bit cell is 4 us.
  localparam int unsigned T_BIT_CYC   = 16;
  localparam int unsigned T_ONE_LOW   = 4;
  localparam int unsigned T_ZERO_LOW  = 12;
  localparam int unsigned T_STOP_LOW  = 4;
  localparam int unsigned T_RSTOP_LOW = 8;
  localparam int unsigned T_IDLE_CYC  = 80;

  function automatic logic [IGR_CNT_W-1:0] igr_sat_inc(input logic [IGR_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/joybus_bit_decoder.sv
// Joybus line front end: synchroniser, edge detector and pulse-width bit decoder.
// A bit is decoded on each falling edge by comparing the previous low and high phase lengths.
module joybus_bit_decoder #(
  parameter int unsigned WAIT_W = 6
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic ctrl_i,
  output logic neg_edge_o,
  output logic bit_o,
  output logic wait_sat_o
);

  logic              sync1_q, sync2_q, hist_q;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [WAIT_W-1:0] low_cnt_q, low_cnt_d;
  logic              pos_edge;

  always_comb begin
    neg_edge_o = hist_q & ~sync2_q;
    pos_edge   = ~hist_q & sync2_q;
    wait_sat_o = &wait_q;
    // A high phase longer than the preceding low phase encodes a 1.
    bit_o      = (low_cnt_q < wait_q);
    wait_d     = wait_q;
    low_cnt_d  = low_cnt_q;
    if (neg_edge_o || pos_edge) begin
      wait_d = '0;
    end else if (!wait_sat_o) begin
      wait_d = wait_q + 1'b1;
    end
    if (pos_edge) begin
      low_cnt_d = wait_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      hist_q    <= 1'b1;
      wait_q    <= '0;
      low_cnt_q <= '0;
    end else begin
      sync1_q   <= ctrl_i;
      sync2_q   <= sync1_q;
      hist_q    <= sync2_q;
      wait_q    <= wait_d;
      low_cnt_q <= low_cnt_d;
    end
  end

endmodule

// File: rtl/n64_joybus_sniffer.sv
// Passive joybus sniffer: captures the controller response that follows CMD_BYTE,
// flags overruns and timeouts, and detects an in-game-reset button combo.
module n64_joybus_sniffer
  import n64_joybus_sniffer_pkg::*;
#(
  parameter logic [7:0]  CMD_BYTE   = 8'h01,
  parameter int unsigned RESP_BITS  = 32,
  parameter int unsigned WAIT_W     = 6,
  parameter int unsigned IGR_FRAMES = 2
) (
  input  logic                 CLK_4M,
  input  logic                 nSRST_4M,
  input  logic                 CTRL,
  output logic [RESP_BITS-1:0] ctrl_data_o,
  output logic                 ctrl_valid_o,
  input  logic                 ctrl_ack_i,
  output logic                 overrun_o,
  output logic                 err_o,
  input  logic [RESP_BITS-1:0] igr_mask_i,
  input  logic [RESP_BITS-1:0] igr_pattern_i,
  input  logic                 igr_en_i,
  output logic                 igr_hit_o,
  output state_t               state_dbg_o
);

  localparam int unsigned BCNT_W = $clog2(RESP_BITS) + 1;
  localparam logic [BCNT_W-1:0] CMD_DONE  = BCNT_W'(CMD_BITS);
  localparam logic [BCNT_W-1:0] RESP_LAST = BCNT_W'(RESP_BITS - 1);
  localparam logic [IGR_CNT_W-1:0] IGR_PRE = IGR_CNT_W'(IGR_FRAMES - 1);

  logic neg_edge, rx_bit, wait_sat;

  joybus_bit_decoder #(
    .WAIT_W (WAIT_W)
  ) u_bit_decoder (
    .clk_i      (CLK_4M),
    .rst_ni     (nSRST_4M),
    .ctrl_i     (CTRL),
    .neg_edge_o (neg_edge),
    .bit_o      (rx_bit),
    .wait_sat_o (wait_sat)
  );

  state_t                 state_q;
  logic [BCNT_W-1:0]      bit_cnt_q;
  logic [CMD_BITS-1:0]    cmd_sr_q;
  logic [RESP_BITS-2:0]   resp_sr_q;
  logic [RESP_BITS-1:0]   data_q;
  logic                   valid_q, overrun_q, err_q, hit_q;
  logic [IGR_CNT_W-1:0]   igr_cnt_q;

  logic [RESP_BITS-1:0]   resp_word;
  logic                   resp_done;
  logic                   igr_match;

  // resp_word is the complete response if the current falling edge decodes its last bit.
  always_comb begin
    resp_word = {rx_bit, resp_sr_q};
    resp_done = (state_q == ST_RESP) && !wait_sat && neg_edge && (bit_cnt_q == RESP_LAST);
    igr_match = (((resp_word ^ igr_pattern_i) & igr_mask_i) == '0);
  end

  // Handshake: ctrl_valid_o rises with each load and falls on the cycle after ctrl_ack_i
  // is sampled high; a load in the same cycle as the ack wins and keeps valid high.
  always_ff @(posedge CLK_4M or negedge nSRST_4M) begin
    if (!nSRST_4M) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      cmd_sr_q  <= '0;
      resp_sr_q <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      err_q     <= 1'b0;
      hit_q     <= 1'b0;
      igr_cnt_q <= '0;
    end else begin
      err_q <= 1'b0;
      hit_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (neg_edge && wait_sat) begin
            state_q   <= ST_CMD;
            bit_cnt_q <= '0;
          end
        end
        ST_CMD: begin
          if (wait_sat) begin
            state_q <= ST_IDLE;
            err_q   <= 1'b1;
          end else if (neg_edge) begin
            if (bit_cnt_q == CMD_DONE) begin
              state_q   <= (cmd_sr_q == CMD_BYTE) ? ST_RESP : ST_IDLE;
              bit_cnt_q <= '0;
            end else begin
              cmd_sr_q  <= {cmd_sr_q[CMD_BITS-2:0], rx_bit};
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end
        ST_RESP: begin
          if (wait_sat) begin
            state_q <= ST_IDLE;
            err_q   <= 1'b1;
          end else if (neg_edge) begin
            if (bit_cnt_q == RESP_LAST) begin
              state_q <= ST_IDLE;
            end else begin
              resp_sr_q <= {rx_bit, resp_sr_q[RESP_BITS-2:1]};
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      if (resp_done) begin
        data_q <= resp_word;
      end

      if (resp_done) begin
        valid_q <= 1'b1;
      end else if (ctrl_ack_i) begin
        valid_q <= 1'b0;
      end

      if (resp_done && valid_q && !ctrl_ack_i) begin
        overrun_q <= 1'b1;
      end

      if (!igr_en_i) begin
        igr_cnt_q <= '0;
      end else if (resp_done) begin
        if (igr_match) begin
          igr_cnt_q <= igr_sat_inc(igr_cnt_q);
          if (igr_cnt_q == IGR_PRE) begin
            hit_q <= 1'b1;
          end
        end else begin
          igr_cnt_q <= '0;
        end
      end
    end
  end

  assign ctrl_data_o  = data_q;
  assign ctrl_valid_o = valid_q;
  assign overrun_o    = overrun_q;
  assign err_o        = err_q;
  assign igr_hit_o    = hit_q;
  assign state_dbg_o  = state_q;

endmodule
